median_frame_ctrl: RTL and testbench

Frame-level sequencer for the 3x3 salt-and-pepper median filter. It accepts a raster-order 8-bit pixel stream and keeps two line buffers plus a 3x3 window register. Each cycle it presents one nine-pixel window to the combinational median9 network and emits the filtered frame in raster order over a valid/ready stream. Border pixels pass through unfiltered, and the block handles start/done framing, backpressure and end-of-frame flush.

---
 rtl/median_frame_ctrl.sv | 179 +++++++++++++++++
 tb/tb_median_frame_ctrl.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/median_frame_ctrl.sv
// Frame sequencer for the 3x3 median filter: line buffers, window register,
// and a registered output stage. Border pixels bypass the median network.
//
// state   | meaning
// --------+----------------------------------------------------------
// S_IDLE  | waiting for start; pipeline empty
// S_RUN   | accepting input pixels, one advance per input handshake
// S_FLUSH | all pixels in; internal ticks drain the last IMG_W+1 windows
module median_frame_ctrl #(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [7:0]  s_data,
  output logic [71:0] win,
  input  logic [7:0]  med_in,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [7:0]  m_data,
  output logic        busy,
  output logic        done
);

  localparam int NPIX = IMG_W * IMG_H;
  localparam int NADV = NPIX + IMG_W + 1;
  localparam int CW   = $clog2(NADV + 1);
  localparam int XW   = $clog2(IMG_W);
  localparam int YW   = $clog2(IMG_H);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   adv_cnt_q, adv_cnt_d;
  logic [CW-1:0]   out_cnt_q, out_cnt_d;
  logic [XW-1:0]   col_q, col_d;
  logic [YW-1:0]   nxt_r_q, nxt_r_d;
  logic [XW-1:0]   nxt_c_q, nxt_c_d;
  logic [71:0]     win_q, win_d;
  logic            win_vld_q, win_vld_d;
  logic            border_q, border_d;
  logic            m_valid_q, m_valid_d;
  logic [7:0]      m_data_q, m_data_d;

  logic [7:0]      lb0 [IMG_W];
  logic [7:0]      lb1 [IMG_W];
  logic [7:0]      lb0_rd, lb1_rd;
  logic            o_load, m_hs, last_out, adv;

  assign lb0_rd = lb0[col_q];
  assign lb1_rd = lb1[col_q];

  assign o_load   = win_vld_q && (!m_valid_q || m_ready);
  assign m_hs     = m_valid_q && m_ready;
  assign last_out = (state_q == S_FLUSH) && m_hs && (out_cnt_q == CW'(NPIX - 1));

  always_comb begin
    state_d   = state_q;
    adv_cnt_d = adv_cnt_q;
    out_cnt_d = out_cnt_q;
    col_d     = col_q;
    nxt_r_d   = nxt_r_q;
    nxt_c_d   = nxt_c_q;
    win_d     = win_q;
    win_vld_d = win_vld_q;
    border_d  = border_q;
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    adv       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_RUN;
          adv_cnt_d = '0;
          out_cnt_d = '0;
          col_d     = '0;
          nxt_r_d   = '0;
          nxt_c_d   = '0;
        end
      end
      S_RUN: begin
        adv = (!win_vld_q || o_load) && s_valid;
        if (adv && (adv_cnt_q == CW'(NPIX - 1))) state_d = S_FLUSH;
      end
      S_FLUSH: begin
        adv = (!win_vld_q || o_load) && (adv_cnt_q < CW'(NADV));
        if (last_out) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (adv) begin
      // shift left; the new column (oldest row on top) enters on the right
      win_d[7:0]   = win_q[15:8];
      win_d[15:8]  = win_q[23:16];
      win_d[23:16] = lb1_rd;
      win_d[31:24] = win_q[39:32];
      win_d[39:32] = win_q[47:40];
      win_d[47:40] = lb0_rd;
      win_d[55:48] = win_q[63:56];
      win_d[63:56] = win_q[71:64];
      win_d[71:64] = s_data;
      adv_cnt_d    = adv_cnt_q + 1'b1;
      col_d        = (col_q == XW'(IMG_W - 1)) ? '0 : col_q + 1'b1;
      if (adv_cnt_q >= CW'(IMG_W + 1)) begin
        win_vld_d = 1'b1;
        border_d  = (nxt_r_q == '0) || (nxt_r_q == YW'(IMG_H - 1)) ||
                    (nxt_c_q == '0) || (nxt_c_q == XW'(IMG_W - 1));
        if (nxt_c_q == XW'(IMG_W - 1)) begin
          nxt_c_d = '0;
          nxt_r_d = (nxt_r_q == YW'(IMG_H - 1)) ? '0 : nxt_r_q + 1'b1;
        end else begin
          nxt_c_d = nxt_c_q + 1'b1;
        end
      end else begin
        win_vld_d = 1'b0;
      end
    end else if (o_load) begin
      win_vld_d = 1'b0;
    end

    if (o_load) begin
      m_valid_d = 1'b1;
      m_data_d  = border_q ? win_q[39:32] : med_in;
    end else if (m_hs) begin
      m_valid_d = 1'b0;
    end

    if (m_hs) out_cnt_d = out_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      adv_cnt_q <= '0;
      out_cnt_q <= '0;
      col_q     <= '0;
      nxt_r_q   <= '0;
      nxt_c_q   <= '0;
      win_q     <= '0;
      win_vld_q <= 1'b0;
      border_q  <= 1'b0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
    end else begin
      state_q   <= state_d;
      adv_cnt_q <= adv_cnt_d;
      out_cnt_q <= out_cnt_d;
      col_q     <= col_d;
      nxt_r_q   <= nxt_r_d;
      nxt_c_q   <= nxt_c_d;
      win_q     <= win_d;
      win_vld_q <= win_vld_d;
      border_q  <= border_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
    end
  end

  // line buffers hold no reset; stale rows only ever feed border windows
  always_ff @(posedge clk) begin
    if (adv) begin
      lb1[col_q] <= lb0_rd;
      lb0[col_q] <= s_data;
    end
  end

  assign s_ready = (state_q == S_RUN) && (!win_vld_q || o_load);
  assign win     = win_q;
  assign m_valid = m_valid_q;
  assign m_data  = m_data_q;
  assign busy    = (state_q != S_IDLE);
  assign done    = last_out;

endmodule

// File: tb/tb_median_frame_ctrl.sv
// Bench for median_frame_ctrl: directed 5x4 frames and random 16x8 frames
// against a neighbourhood-median reference computed from the stored image.
module tb_median_frame_ctrl;

  localparam int BUDGET = 4000;

  logic clk = 1'b0;
  logic rst, start, s_valid, m_ready, sel;
  logic [7:0] s_data;

  logic        a_s_ready, a_m_valid, a_busy, a_done;
  logic [7:0]  a_m_data, a_med;
  logic [71:0] a_win;
  logic        b_s_ready, b_m_valid, b_busy, b_done;
  logic [7:0]  b_m_data, b_med;
  logic [71:0] b_win;

  logic        s_ready, m_valid, busy, done;
  logic [7:0]  m_data;

  int n_assert = 0;
  int n_fail   = 0;
  int W, H, N;
  logic [7:0] img [128];

  always #5 clk = ~clk;

  function automatic logic [7:0] med9(input logic [71:0] w);
    logic [7:0] v [9];
    logic [7:0] t;
    for (int i = 0; i < 9; i++) v[i] = w[8*i +: 8];
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8 - i; j++)
        if (v[j] > v[j+1]) begin t = v[j]; v[j] = v[j+1]; v[j+1] = t; end
    return v[4];
  endfunction

  assign a_med = med9(a_win);
  assign b_med = med9(b_win);

  median_frame_ctrl #(.IMG_W(5), .IMG_H(4)) u_a (
    .clk(clk), .rst(rst), .start(start && !sel), .s_valid(s_valid),
    .s_ready(a_s_ready), .s_data(s_data), .win(a_win), .med_in(a_med),
    .m_valid(a_m_valid), .m_ready(m_ready), .m_data(a_m_data),
    .busy(a_busy), .done(a_done));

  median_frame_ctrl #(.IMG_W(16), .IMG_H(8)) u_b (
    .clk(clk), .rst(rst), .start(start && sel), .s_valid(s_valid),
    .s_ready(b_s_ready), .s_data(s_data), .win(b_win), .med_in(b_med),
    .m_valid(b_m_valid), .m_ready(m_ready), .m_data(b_m_data),
    .busy(b_busy), .done(b_done));

  always_comb begin
    s_ready = sel ? b_s_ready : a_s_ready;
    m_valid = sel ? b_m_valid : a_m_valid;
    m_data  = sel ? b_m_data  : a_m_data;
    busy    = sel ? b_busy    : a_busy;
    done    = sel ? b_done    : a_done;
  end

  // reference: border copies the pixel, interior takes the 3x3 median
  function automatic logic [7:0] gold(input int k);
    int r, c, lt, le;
    logic [7:0] v [9];
    r = k / W;
    c = k % W;
    if (r == 0 || r == H - 1 || c == 0 || c == W - 1) return img[k];
    for (int dr = 0; dr < 3; dr++)
      for (int dc = 0; dc < 3; dc++)
        v[dr*3 + dc] = img[(r + dr - 1) * W + (c + dc - 1)];
    for (int i = 0; i < 9; i++) begin
      lt = 0; le = 0;
      for (int j = 0; j < 9; j++) begin
        if (v[j] <  v[i]) lt++;
        if (v[j] <= v[i]) le++;
      end
      if (lt <= 4 && le >= 5) return v[i];
    end
    return 8'h00;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic fill(input logic [7:0] bg);
    for (int i = 0; i < N; i++) img[i] = bg;
  endtask

  task automatic fill_random();
    for (int i = 0; i < N; i++) img[i] = 8'($urandom_range(0, 255));
  endtask

  // entered and left just after a rising edge
  task automatic run_frame(input int sv_pct, input int mr_pct, input bit lat_chk,
                           input bit busy_starts, input int rst_at);
    int in_idx = 0, out_idx = 0, it = 0, i0 = -1, i1 = -1;
    bit stall = 0, sr_done = 0, sf_done = 0;
    logic [7:0] held = 8'h00;
    start = 1; s_valid = 0; m_ready = 0;
    @(posedge clk); #1;
    start = 0;
    while (out_idx < N && it < BUDGET) begin
      s_valid = (in_idx < N) && ($urandom_range(0, 99) < sv_pct);
      s_data  = (in_idx < N) ? img[in_idx] : 8'h00;
      m_ready = ($urandom_range(0, 99) < mr_pct);
      start   = 0;
      if (busy_starts && !sr_done && in_idx == N / 2) begin start = 1; sr_done = 1; end
      if (busy_starts && !sf_done && in_idx == N && out_idx < N - 2) begin start = 1; sf_done = 1; end
      @(negedge clk);
      chk("busy_in_frame", busy, 1);
      if (stall) begin
        chk("stall_valid", m_valid, 1);
        chk("stall_data", m_data, held);
      end
      if (m_valid && i1 < 0) begin
        i1 = it;
        if (lat_chk) chk("first_latency", i1 - 1 - i0, W + 2);
      end
      chk("done", done, m_valid && m_ready && out_idx == N - 1);
      if (s_valid && s_ready) begin
        if (i0 < 0) i0 = it;
        in_idx++;
      end
      if (m_valid && m_ready) begin
        chk($sformatf("pixel_%0d", out_idx), m_data, gold(out_idx));
        out_idx++;
      end
      stall = m_valid && !m_ready;
      held  = m_data;
      @(posedge clk); #1;
      it++;
      if (rst_at > 0 && out_idx == rst_at) begin
        rst = 1; s_valid = 0; m_ready = 0;
        @(posedge clk); #1;
        rst = 0;
        chk("rst_mid_m_valid", m_valid, 0);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_s_ready", s_ready, 0);
        return;
      end
    end
    s_valid = 0;
    chk("timeout", it < BUDGET, 1);
    chk("out_count", out_idx, N);
    chk("busy_after_done", busy, 0);
    chk("done_after", done, 0);
  endtask

  initial begin
    sel = 0; W = 5; H = 4; N = 20;
    rst = 1; start = 0; s_valid = 0; m_ready = 0; s_data = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_s_ready", s_ready, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_win_zero", a_win == 72'h0, 1);
    rst = 0;
    @(posedge clk); #1;

    fill(8'd100);
    run_frame(100, 100, 1, 0, 0);

    fill(8'd50); img[1*W + 2] = 8'd255;
    run_frame(100, 100, 0, 0, 0);
    fill(8'd50); img[2*W + 2] = 8'd0;
    run_frame(100, 100, 0, 0, 0);
    fill(8'd50); img[0] = 8'd0; img[3*W + 4] = 8'd255;
    run_frame(80, 60, 0, 1, 0);

    sel = 1; W = 16; H = 8; N = 128;
    fill_random();
    run_frame(70, 50, 0, 1, 0);
    fill_random();
    run_frame(80, 50, 0, 0, 7);
    fill_random();
    run_frame(75, 50, 0, 0, 0);
    fill_random();
    run_frame(100, 100, 1, 1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
